// File: rtl/alu_control_sequencer_pkg.sv
// Shared definitions for the hardwired control unit: ALU opcodes, sequencer
// state encoding and instruction-register field positions.
package cpu_defs_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_ROR  = 5'b01011;
   localparam logic [4:0] OP_ROL  = 5'b01100;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [2:0] ST_T0   = 3'd0;
   localparam logic [2:0] ST_T1   = 3'd1;
   localparam logic [2:0] ST_T2   = 3'd2;
   localparam logic [2:0] ST_T3   = 3'd3;
   localparam logic [2:0] ST_T4   = 3'd4;
   localparam logic [2:0] ST_T5   = 3'd5;
   localparam logic [2:0] ST_T6   = 3'd6;
   localparam logic [2:0] ST_HALT = 3'd7;

   localparam int IR_OP_HI = 31;
   localparam int IR_OP_LO = 27;
   localparam int IR_RA_HI = 26;
   localparam int IR_RA_LO = 23;
   localparam int IR_RB_HI = 22;
   localparam int IR_RB_LO = 19;
   localparam int IR_RC_HI = 18;
   localparam int IR_RC_LO = 15;

   typedef enum logic [2:0] {
      CLS_TWO,
      CLS_MULDIV,
      CLS_UNARY,
      CLS_NOP,
      CLS_HALT,
      CLS_ILLEGAL
   } op_class_t;

   function automatic op_class_t op_class(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHL, OP_SHRA, OP_ROR, OP_ROL:       op_class = CLS_TWO;
         OP_MUL, OP_DIV:                        op_class = CLS_MULDIV;
         OP_NEG, OP_NOT:                        op_class = CLS_UNARY;
         OP_NOP:                                op_class = CLS_NOP;
         OP_HALT:                               op_class = CLS_HALT;
         default:                               op_class = CLS_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/alu_control_sequencer_if.sv
// Control bundle between the sequencer (master) and the single-bus datapath (slave).
interface alu_control_sequencer_if #(
   parameter int NREGS = 16,
   parameter int OPW   = 5
);
   logic [31:0]      ir;
   logic             mem_done;
   logic             stop;
   logic [NREGS-1:0] reg_in;
   logic [NREGS-1:0] reg_out;
   logic             PCout, PCin, incPC, MARin, MDRin, MDRout, read, IRin;
   logic             Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
   logic [OPW-1:0]   opcode;
   logic             run;
   logic             illegal;

   modport master (
      input  ir, mem_done, stop,
      output reg_in, reg_out,
      output PCout, PCin, incPC, MARin, MDRin, MDRout, read, IRin,
      output Yin, Zin, ZLowOut, ZHighOut, HIin, LOin,
      output opcode, run, illegal
   );

   modport slave (
      output ir, mem_done, stop,
      input  reg_in, reg_out,
      input  PCout, PCin, incPC, MARin, MDRin, MDRout, read, IRin,
      input  Yin, Zin, ZLowOut, ZHighOut, HIin, LOin,
      input  opcode, run, illegal
   );
endinterface

// File: rtl/alu_control_sequencer_reg_select_decoder.sv
// 4-bit register index to one-hot strobe vector; all zero when disabled.
module reg_select_decoder #(
   parameter int NREGS = 16
) (
   input  logic [3:0]       idx,
   input  logic             en,
   output logic [NREGS-1:0] onehot
);
   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (en && (idx == 4'(i))) onehot[i] = 1'b1;
      end
   end
endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/execute sequencer (T0..T6, HALT) for register-register ALU
// instructions on the single-bus datapath.
module alu_control_sequencer
   import cpu_defs_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int OPW   = 5
) (
   input logic                     clock,
   input logic                     clear,
   alu_control_sequencer_if.master bus
);
   logic [2:0] state, state_nxt;
   logic       cleared;
   logic       stop_pending;
   logic       illegal_q;
   logic       final_step;
   op_class_t  cls;
   logic [3:0] ra, rb, rc;
   logic       in_en, out_en;
   logic [3:0] in_idx, out_idx;
   logic       zin;
   logic       unused_ir;

   assign cls       = op_class(bus.ir[IR_OP_HI:IR_OP_LO]);
   assign ra        = bus.ir[IR_RA_HI:IR_RA_LO];
   assign rb        = bus.ir[IR_RB_HI:IR_RB_LO];
   assign rc        = bus.ir[IR_RC_HI:IR_RC_LO];
   assign unused_ir = ^bus.ir[IR_RC_LO-1:0];

   always_comb begin
      state_nxt  = state;
      final_step = 1'b0;
      case (state)
         ST_T0: state_nxt = ST_T1;
         ST_T1: if (bus.mem_done) state_nxt = ST_T2;
         ST_T2: state_nxt = ST_T3;
         ST_T3: begin
            case (cls)
               CLS_TWO, CLS_MULDIV, CLS_UNARY: state_nxt = ST_T4;
               CLS_NOP:                        final_step = 1'b1;
               default:                        state_nxt = ST_HALT;
            endcase
         end
         ST_T4: begin
            if (cls == CLS_TWO || cls == CLS_MULDIV) state_nxt = ST_T5;
            else                                     final_step = 1'b1;
         end
         ST_T5: begin
            if (cls == CLS_MULDIV) state_nxt = ST_T6;
            else                   final_step = 1'b1;
         end
         ST_T6:   final_step = 1'b1;
         default: state_nxt = ST_HALT;
      endcase
      if (final_step) state_nxt = (bus.stop || stop_pending) ? ST_HALT : ST_T0;
   end

   // The first cycle after a clear edge is a quiet T0 (no strobes); stepping
   // resumes from a real T0 on the following edge. A stop seen at any point of
   // an instruction is held until its final execute step.
   always_ff @(posedge clock) begin
      if (clear) begin
         state        <= ST_T0;
         cleared      <= 1'b1;
         stop_pending <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         cleared <= 1'b0;
         if (!cleared) state <= state_nxt;
         if (final_step && !cleared) stop_pending <= 1'b0;
         else                        stop_pending <= stop_pending | bus.stop;
         if (!cleared && state == ST_T3 && cls == CLS_ILLEGAL) illegal_q <= 1'b1;
      end
   end

   always_comb begin
      bus.PCout    = 1'b0;
      bus.PCin     = 1'b0;
      bus.incPC    = 1'b0;
      bus.MARin    = 1'b0;
      bus.MDRin    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.read     = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.ZLowOut  = 1'b0;
      bus.ZHighOut = 1'b0;
      bus.HIin     = 1'b0;
      bus.LOin     = 1'b0;
      zin          = 1'b0;
      in_en        = 1'b0;
      out_en       = 1'b0;
      in_idx       = '0;
      out_idx      = '0;
      if (!cleared) begin
         case (state)
            ST_T0: begin
               bus.PCout = 1'b1;
               bus.MARin = 1'b1;
               bus.incPC = 1'b1;
               zin       = 1'b1;
            end
            ST_T1: begin
               bus.ZLowOut = 1'b1;
               bus.read    = 1'b1;
               bus.MDRin   = 1'b1;
               bus.PCin    = bus.mem_done;
            end
            ST_T2: begin
               bus.MDRout = 1'b1;
               bus.IRin   = 1'b1;
            end
            ST_T3: begin
               case (cls)
                  CLS_TWO:    begin out_en = 1'b1; out_idx = rb; bus.Yin = 1'b1; end
                  CLS_MULDIV: begin out_en = 1'b1; out_idx = ra; bus.Yin = 1'b1; end
                  CLS_UNARY:  begin out_en = 1'b1; out_idx = rb; zin = 1'b1; end
                  default:    ;
               endcase
            end
            ST_T4: begin
               case (cls)
                  CLS_TWO:    begin out_en = 1'b1; out_idx = rc; zin = 1'b1; end
                  CLS_MULDIV: begin out_en = 1'b1; out_idx = rb; zin = 1'b1; end
                  CLS_UNARY:  begin bus.ZLowOut = 1'b1; in_en = 1'b1; in_idx = ra; end
                  default:    ;
               endcase
            end
            ST_T5: begin
               case (cls)
                  CLS_TWO:    begin bus.ZLowOut = 1'b1; in_en = 1'b1; in_idx = ra; end
                  CLS_MULDIV: begin bus.ZLowOut = 1'b1; bus.LOin = 1'b1; end
                  default:    ;
               endcase
            end
            ST_T6: begin
               if (cls == CLS_MULDIV) begin
                  bus.ZHighOut = 1'b1;
                  bus.HIin     = 1'b1;
               end
            end
            default: ;
         endcase
      end
      bus.Zin     = zin;
      bus.opcode  = zin ? OPW'(bus.ir[IR_OP_HI:IR_OP_LO]) : '0;
      bus.run     = (state != ST_HALT);
      bus.illegal = illegal_q;
   end

   reg_select_decoder #(.NREGS(NREGS)) u_in_dec (
      .idx    (in_idx),
      .en     (in_en),
      .onehot (bus.reg_in)
   );

   reg_select_decoder #(.NREGS(NREGS)) u_out_dec (
      .idx    (out_idx),
      .en     (out_en),
      .onehot (bus.reg_out)
   );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: directed and random instructions checked
// cycle by cycle against a per-instruction expected strobe table.
module tb_alu_control_sequencer;

   logic clock = 1'b0;
   logic clear = 1'b1;

   alu_control_sequencer_if #(.NREGS(16), .OPW(5)) bus ();

   alu_control_sequencer #(.NREGS(16), .OPW(5)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [15:0] rin;
      logic [15:0] rout;
      logic PCout, PCin, incPC, MARin, MDRin, MDRout, read, IRin;
      logic Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
      logic [4:0] opc;
      logic run;
      logic ill;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   logic [4:0] legal_ops [15] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                  5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01111,
                                  5'b10000, 5'b10001, 5'b10010, 5'b11010, 5'b11011};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic exp_t observe();
      exp_t e;
      e.rin = bus.reg_in;     e.rout = bus.reg_out;
      e.PCout = bus.PCout;    e.PCin = bus.PCin;     e.incPC = bus.incPC;
      e.MARin = bus.MARin;    e.MDRin = bus.MDRin;   e.MDRout = bus.MDRout;
      e.read = bus.read;      e.IRin = bus.IRin;     e.Yin = bus.Yin;
      e.Zin = bus.Zin;        e.ZLowOut = bus.ZLowOut; e.ZHighOut = bus.ZHighOut;
      e.HIin = bus.HIin;      e.LOin = bus.LOin;     e.opc = bus.opcode;
      e.run = bus.run;        e.ill = bus.illegal;
      return e;
   endfunction

   function automatic exp_t idle_word();
      exp_t e = '0;
      e.run = 1'b1;
      return e;
   endfunction

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] c);
      return {op, a, b, c, 15'd0};
   endfunction

   // 0 two-operand, 1 mul/div, 2 unary, 3 nop, 4 halt, 5 undefined
   function automatic int group_of(input logic [4:0] op);
      case (op)
         5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
         5'b01001, 5'b01010, 5'b01011, 5'b01100: return 0;
         5'b01111, 5'b10000:                     return 1;
         5'b10001, 5'b10010:                     return 2;
         5'b11010:                               return 3;
         5'b11011:                               return 4;
         default:                                return 5;
      endcase
   endfunction

   // Expected output per cycle of one instruction, starting at T0.
   task automatic model_instr(input logic [31:0] irv, input int w, input int stop_cyc,
                              output bit halts);
      exp_t e;
      logic [4:0] op = irv[31:27];
      int ra = int'(irv[26:23]);
      int rb = int'(irv[22:19]);
      int rc = int'(irv[18:15]);
      int g  = group_of(op);
      bit ill = 1'b0;
      halts = 1'b0;
      exp_q.delete();
      e = idle_word(); e.PCout = 1; e.MARin = 1; e.incPC = 1; e.Zin = 1; e.opc = op;
      exp_q.push_back(e);
      for (int i = 0; i <= w; i++) begin
         e = idle_word(); e.ZLowOut = 1; e.read = 1; e.MDRin = 1; e.PCin = (i == w);
         exp_q.push_back(e);
      end
      e = idle_word(); e.MDRout = 1; e.IRin = 1;
      exp_q.push_back(e);
      case (g)
         0: begin
            e = idle_word(); e.rout = 16'd1 << rb; e.Yin = 1; exp_q.push_back(e);
            e = idle_word(); e.rout = 16'd1 << rc; e.Zin = 1; e.opc = op; exp_q.push_back(e);
            e = idle_word(); e.ZLowOut = 1; e.rin = 16'd1 << ra; exp_q.push_back(e);
         end
         1: begin
            e = idle_word(); e.rout = 16'd1 << ra; e.Yin = 1; exp_q.push_back(e);
            e = idle_word(); e.rout = 16'd1 << rb; e.Zin = 1; e.opc = op; exp_q.push_back(e);
            e = idle_word(); e.ZLowOut = 1; e.LOin = 1; exp_q.push_back(e);
            e = idle_word(); e.ZHighOut = 1; e.HIin = 1; exp_q.push_back(e);
         end
         2: begin
            e = idle_word(); e.rout = 16'd1 << rb; e.Zin = 1; e.opc = op; exp_q.push_back(e);
            e = idle_word(); e.ZLowOut = 1; e.rin = 16'd1 << ra; exp_q.push_back(e);
         end
         3: exp_q.push_back(idle_word());
         4: begin exp_q.push_back(idle_word()); halts = 1'b1; end
         default: begin exp_q.push_back(idle_word()); halts = 1'b1; ill = 1'b1; end
      endcase
      if (stop_cyc >= 0 && stop_cyc < exp_q.size()) halts = 1'b1;
      if (halts) begin
         e = '0; e.ill = ill;
         repeat (3) exp_q.push_back(e);
      end
   endtask

   task automatic do_clear(input int n);
      @(posedge clock); #1 clear = 1'b1;
      repeat (n) @(posedge clock);
      #1 clear = 1'b0;
      bus.stop = 1'b0;
      @(negedge clock);
      check("clear_idle", 64'(observe()), 64'(idle_word()));
   endtask

   task automatic run_instr(input logic [31:0] irv, input int w, input int stop_cyc,
                            input int abort_cyc, input string name);
      bit halts;
      model_instr(irv, w, stop_cyc, halts);
      for (int k = 0; k < exp_q.size(); k++) begin
         @(posedge clock); #1;
         if (k == 0) bus.ir = irv;
         if (k >= 1 && k <= w)  bus.mem_done = 1'b0;
         else if (k == w + 1)   bus.mem_done = 1'b1;
         else                   bus.mem_done = 1'($urandom_range(0, 1));
         bus.stop = (k == stop_cyc);
         clear    = (k == abort_cyc);
         @(negedge clock);
         check($sformatf("%s c%0d", name, k), 64'(observe()), 64'(exp_q[k]));
         if (k == abort_cyc) begin
            @(posedge clock); #1 clear = 1'b0; bus.stop = 1'b0;
            @(negedge clock);
            check($sformatf("%s abort", name), 64'(observe()), 64'(idle_word()));
            return;
         end
      end
      if (halts) do_clear(1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      bus.ir       = '0;
      bus.mem_done = 1'b1;
      bus.stop     = 1'b0;
      do_clear(2);

      run_instr(32'h521B8000, 0, -1, -1, "shra");
      run_instr(32'h521B8000, 3, -1, -1, "shra_wait");
      run_instr(32'h79900000, 0, -1, -1, "mul");
      run_instr(32'h89100000, 0, -1, -1, "neg");
      run_instr(32'hF8000000, 0, -1, -1, "undef");
      run_instr(mk_ir(5'b00011, 4'd1, 4'd2, 4'd3), 0, 1, -1, "add_stop");
      run_instr(mk_ir(5'b00011, 4'd5, 4'd6, 4'd7), 1, -1, 5, "add_abort_t4");
      run_instr(mk_ir(5'b10000, 4'd15, 4'd0, 4'd9), 2, -1, -1, "div");
      run_instr(mk_ir(5'b10010, 4'd8, 4'd15, 4'd1), 1, -1, -1, "not");
      run_instr(mk_ir(5'b11010, 4'd3, 4'd3, 4'd3), 0, -1, -1, "nop");
      run_instr(mk_ir(5'b11010, 4'd3, 4'd3, 4'd3), 0, 3, -1, "nop_stop");
      run_instr(mk_ir(5'b11011, 4'd0, 4'd0, 4'd0), 0, -1, -1, "halt");
      run_instr(mk_ir(5'b01111, 4'd4, 4'd5, 4'd6), 0, 6, -1, "mul_stop_last");

      for (int n = 0; n < 80; n++) begin
         logic [4:0]  op;
         logic [31:0] irv;
         int w, sc, ac, r;
         if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 14)];
         else                          op = 5'($urandom_range(0, 31));
         irv = mk_ir(op, 4'($urandom), 4'($urandom), 4'($urandom));
         irv[14:0] = 15'($urandom);
         w  = $urandom_range(0, 3);
         sc = -1;
         ac = -1;
         r  = $urandom_range(0, 9);
         if (r == 0)      sc = $urandom_range(0, 3);
         else if (r == 1) ac = $urandom_range(0, 3);
         run_instr(irv, w, sc, ac, $sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
